// File: rtl/mic_pkg.sv
// Shared constants, serializer state encoding and channel-index width helper
// for the I2S microphone-array receiver.
package mic_pkg;

  localparam int unsigned I2S_SLOT_BITS = 32;
  localparam int unsigned DC_SHIFT      = 10;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_e;

  function automatic int unsigned ch_idx_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/mic_decimator.sv
// Per-channel boxcar decimator: accumulate DECIM frames, emit floor average.
// Optional DC-removal stage when MIC_DC_BLOCK_EN is defined (adds one register).
module mic_decimator import mic_pkg::*; #(
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned DECIM    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stb_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                vld_out,
  output logic [SAMPLE_W-1:0] data_out
);

  localparam int unsigned LOG2_D = $clog2(DECIM);
  localparam int unsigned AW     = SAMPLE_W + LOG2_D;
  localparam int unsigned CW     = (LOG2_D > 0) ? LOG2_D : 1;

  logic signed [SAMPLE_W-1:0] smp;
  logic                       smp_stb;

`ifdef MIC_DC_BLOCK_EN
  localparam int unsigned DW = SAMPLE_W + DC_SHIFT;
  localparam logic signed [DW-1:0] SMAX = DW'(2**(SAMPLE_W-1) - 1);
  localparam logic signed [DW-1:0] SMIN = -SMAX - DW'(1);

  logic signed [DW-1:0]       dc_q, dc_d, x_ext, diff;
  logic signed [SAMPLE_W-1:0] x_q, x_d;
  logic                       stb_q, stb_d;

  always_comb begin
    x_ext = DW'(signed'(sample_in));
    diff  = x_ext - dc_q;
    dc_d  = dc_q;
    x_d   = x_q;
    stb_d = stb_in;
    if (stb_in) begin
      // Output uses the estimate from before this frame's update.
      dc_d = dc_q + (diff >>> DC_SHIFT);
      if (diff > SMAX)      x_d = SAMPLE_W'(SMAX);
      else if (diff < SMIN) x_d = SAMPLE_W'(SMIN);
      else                  x_d = SAMPLE_W'(diff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_q  <= '0;
      x_q   <= '0;
      stb_q <= 1'b0;
    end else begin
      dc_q  <= dc_d;
      x_q   <= x_d;
      stb_q <= stb_d;
    end
  end

  assign smp     = x_q;
  assign smp_stb = stb_q;
`else
  assign smp     = sample_in;
  assign smp_stb = stb_in;
`endif

  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last;

  always_comb begin
    sum      = acc_q + AW'(smp);
    last     = (cnt_q == CW'(DECIM - 1));
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    vld_out  = smp_stb && last;
    data_out = SAMPLE_W'(sum >>> LOG2_D);
    if (smp_stb) begin
      acc_d = last ? '0 : sum;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mic_array_rx.sv
// I2S controller + multi-line capture + per-channel decimation + AXI-stream out.
// MIC_DC_BLOCK_EN enables per-channel DC removal inside mic_decimator.
module mic_array_rx import mic_pkg::*; #(
  parameter int unsigned NUM_LINES = 2,
  parameter int unsigned SAMPLE_W  = 24,
  parameter int unsigned SCK_DIV   = 16,
  parameter int unsigned DECIM     = 8,
  parameter int unsigned OUT_W     = 32
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [NUM_LINES-1:0]           mic_data_in,
  output logic                           mic_sck_out,
  output logic                           mic_ws_out,
  output logic [OUT_W-1:0]               m_axis_tdata,
  output logic [$clog2(2*NUM_LINES)-1:0] m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           overflow_out
);

  localparam int unsigned NCH  = 2 * NUM_LINES;
  localparam int unsigned UW   = ch_idx_w(NCH);
  localparam int unsigned DIVW = $clog2(SCK_DIV);
  localparam int unsigned BW   = $clog2(2 * I2S_SLOT_BITS);
  localparam int unsigned NW   = BW - 1;

  // Asynchronous assert, synchronous release of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_q <= '0;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [DIVW-1:0]     div_q, div_d;
  logic                sck_q, sck_d, ws_q, ws_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                tick, rise_stb, fall_stb, capture, park, frame_stb;
  logic [NW-1:0]       bit_n;
  logic [SAMPLE_W-1:0] shift_q [NUM_LINES];
  logic [SAMPLE_W-1:0] shift_d [NUM_LINES];
  logic [SAMPLE_W-1:0] left_q  [NUM_LINES];
  logic [SAMPLE_W-1:0] left_d  [NUM_LINES];
  logic [SAMPLE_W-1:0] word_in [NUM_LINES];
  logic [SAMPLE_W-1:0] smp     [NCH];

  always_comb begin
    tick     = (div_q == DIVW'(SCK_DIV - 1));
    rise_stb = tick && !sck_q;
    fall_stb = tick && sck_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    sck_d    = sck_q ^ tick;
    bit_d    = rise_stb ? bit_q + 1'b1 : bit_q;
    // bit_q already counts the edge just taken, so its MSB is the next slot.
    ws_d     = fall_stb ? bit_q[BW-1] : ws_q;
    bit_n    = bit_q[NW-1:0];
    capture  = rise_stb && (bit_n != '0) && (bit_n <= NW'(SAMPLE_W));
    park     = rise_stb && !bit_q[BW-1] && (bit_n == NW'(SAMPLE_W));
    frame_stb = rise_stb && bit_q[BW-1] && (bit_n == NW'(SAMPLE_W));
    shift_d  = shift_q;
    left_d   = left_q;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      word_in[i]   = {shift_q[i][SAMPLE_W-2:0], mic_data_in[i]};
      if (capture) shift_d[i] = word_in[i];
      if (park)    left_d[i]  = word_in[i];
      smp[2*i]     = left_q[i];
      smp[2*i+1]   = word_in[i];
    end
  end

  logic [NCH-1:0]      dec_vld;
  logic [SAMPLE_W-1:0] dec_data [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_dec
    mic_decimator #(
      .SAMPLE_W (SAMPLE_W),
      .DECIM    (DECIM)
    ) u_dec (
      .clk       (clk_in),
      .rst_n     (rst_n),
      .stb_in    (frame_stb),
      .sample_in (smp[c]),
      .vld_out   (dec_vld[c]),
      .data_out  (dec_data[c])
    );
  end

  ser_state_e          state_q, state_d;
  logic [UW-1:0]       idx_q, idx_d;
  logic [SAMPLE_W-1:0] obuf_q [NCH];
  logic [SAMPLE_W-1:0] obuf_d [NCH];
  logic                ovf_q, ovf_d;
  logic                frame_in, last_beat;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    obuf_d        = obuf_q;
    ovf_d         = ovf_q;
    frame_in      = &dec_vld;
    m_axis_tvalid = (state_q == S_SEND);
    m_axis_tlast  = m_axis_tvalid && (idx_q == UW'(NCH - 1));
    m_axis_tuser  = m_axis_tvalid ? idx_q : '0;
    m_axis_tdata  = m_axis_tvalid ? OUT_W'(signed'(obuf_q[idx_q])) : '0;
    last_beat     = m_axis_tlast && m_axis_tready;
    case (state_q)
      S_SEND: begin
        if (m_axis_tready) begin
          if (m_axis_tlast) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // A frame arriving while the previous one is still streaming is dropped.
    if (frame_in) begin
      if (state_q == S_IDLE || last_beat) begin
        obuf_d  = dec_data;
        state_d = S_SEND;
        idx_d   = '0;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      bit_q   <= '0;
      shift_q <= '{default: '0};
      left_q  <= '{default: '0};
      state_q <= S_IDLE;
      idx_q   <= '0;
      obuf_q  <= '{default: '0};
      ovf_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      left_q  <= left_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      obuf_q  <= obuf_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mic_sck_out  = sck_q;
  assign mic_ws_out   = ws_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_mic_array_rx.sv
// Directed bench for mic_array_rx: three configurations driven by an I2S mic model.
module tb_mic_array_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // u0: 1 line, DECIM=1   u1: 2 lines, DECIM=4   u2: 1 line, DECIM=2
  logic        sd0 = 1'b0, sck0, ws0, v0, l0, u0u, ovf0;
  logic [31:0] d0;
  logic        rdy0 = 1'b1;
  logic [1:0]  sd1 = '0;
  logic        sck1, ws1, v1, l1, ovf1;
  logic [1:0]  u1u;
  logic [31:0] d1;
  logic        rdy1 = 1'b1;
  logic        sd2 = 1'b0, sck2, ws2, v2, l2, u2u, ovf2;
  logic [31:0] d2;
  logic        rdy2 = 1'b1;

  mic_array_rx #(.NUM_LINES(1), .SAMPLE_W(24), .SCK_DIV(2), .DECIM(1), .OUT_W(32)) u0 (
    .clk_in(clk), .rst_n_in(rst_n), .mic_data_in(sd0), .mic_sck_out(sck0), .mic_ws_out(ws0),
    .m_axis_tdata(d0), .m_axis_tuser(u0u), .m_axis_tvalid(v0), .m_axis_tready(rdy0),
    .m_axis_tlast(l0), .overflow_out(ovf0));

  mic_array_rx #(.NUM_LINES(2), .SAMPLE_W(24), .SCK_DIV(2), .DECIM(4), .OUT_W(32)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .mic_data_in(sd1), .mic_sck_out(sck1), .mic_ws_out(ws1),
    .m_axis_tdata(d1), .m_axis_tuser(u1u), .m_axis_tvalid(v1), .m_axis_tready(rdy1),
    .m_axis_tlast(l1), .overflow_out(ovf1));

  mic_array_rx #(.NUM_LINES(1), .SAMPLE_W(24), .SCK_DIV(2), .DECIM(2), .OUT_W(32)) u2 (
    .clk_in(clk), .rst_n_in(rst_n), .mic_data_in(sd2), .mic_sck_out(sck2), .mic_ws_out(ws2),
    .m_axis_tdata(d2), .m_axis_tuser(u2u), .m_axis_tvalid(v2), .m_axis_tready(rdy2),
    .m_axis_tlast(l2), .overflow_out(ovf2));

  // Mic words per frame (index = frame mod 16); channel order L,R per line.
  logic [23:0] w0l [16], w0r [16], w2l [16], w2r [16];
  logic [23:0] w1 [4][16];

  // All instances share SCK_DIV and reset, so one position counter serves them all.
  int unsigned tx_pos = 0, tx_frm = 0;
  always @(posedge sck0 or negedge rst_n) begin
    if (!rst_n) begin
      tx_pos = 0;
      tx_frm = 0;
    end else if (tx_pos == 63) begin
      tx_pos = 0;
      tx_frm++;
    end else begin
      tx_pos++;
    end
  end

  function automatic logic sd_bit(input logic [23:0] l, input logic [23:0] r,
                                  input int unsigned pos);
    logic [23:0] w;
    int unsigned n;
    n = pos % 32;
    w = (pos < 32) ? l : r;
    if (n >= 1 && n <= 24) return w[24-n];
    return 1'b0;
  endfunction

  always @(negedge sck0) begin
    sd0 <= sd_bit(w0l[tx_frm % 16], w0r[tx_frm % 16], tx_pos);
    sd1 <= {sd_bit(w1[2][tx_frm % 16], w1[3][tx_frm % 16], tx_pos),
            sd_bit(w1[0][tx_frm % 16], w1[1][tx_frm % 16], tx_pos)};
    sd2 <= sd_bit(w2l[tx_frm % 16], w2r[tx_frm % 16], tx_pos);
  end

  function automatic logic [63:0] mk(input logic last, input logic [2:0] user,
                                     input logic [31:0] data);
    return {28'd0, last, user, data};
  endfunction

  logic [63:0] q0 [$], q1 [$], q2 [$];
  always @(negedge clk) begin
    if (v0 && rdy0) q0.push_back(mk(l0, {2'b00, u0u}, d0));
    if (v1 && rdy1) q1.push_back(mk(l1, {1'b0, u1u}, d1));
    if (v2 && rdy2) q2.push_back(mk(l2, {2'b00, u2u}, d2));
  end

  int n_chk = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  int cnt;

  initial begin
    for (int unsigned k = 0; k < 16; k++) begin
      w0l[k] = 24'h123456;
      w0r[k] = 24'hFEDCBA;
      w2l[k] = '0;
      w2r[k] = '0;
      for (int unsigned c = 0; c < 4; c++) w1[c][k] = '0;
    end
    w1[0][0] = 24'd4;      w1[0][1] = 24'd8;      w1[0][2] = 24'd12;     w1[0][3] = 24'd16;
    w1[1][0] = 24'hFFFFFF; w1[1][1] = 24'hFFFFFF; w1[1][2] = 24'hFFFFFF; w1[1][3] = 24'hFFFFFE;
    w1[2][0] = 24'd100;    w1[2][1] = 24'd200;    w1[2][2] = 24'd300;    w1[2][3] = 24'd400;
    for (int unsigned k = 0; k < 4; k++) w1[3][k] = 24'h7FFFFF;
    w2l[0] = 24'hFFFFFD; w2l[1] = 24'hFFFFFE;
    w2r[0] = 24'd5;      w2r[1] = 24'd6;

    // Reset state
    #3 rst_n = 1'b0;
    repeat (5) tick1();
    check("rst_sck", sck0, 0);
    check("rst_ws", ws0, 0);
    check("rst_tvalid", v0, 0);
    check("rst_tdata", d0, 0);
    check("rst_tuser", u0u, 0);
    check("rst_tlast", l0, 0);
    check("rst_ovf", ovf0, 0);

    // First SCK rise: 2 synchronizer cycles + SCK_DIV
    rst_n = 1'b1;
    cnt = 0;
    while (!sck0 && cnt < 50) begin
      tick1();
      cnt++;
    end
    check("sck_first_rise", cnt, 4);
    check("ws_at_first_rise", ws0, 0);

    cnt = 0;
    while (tx_pos != 34 && cnt < 1000) begin tick1(); cnt++; end
    check("ws_right_slot", ws0, 1);
    cnt = 0;
    while (tx_pos != 2 && cnt < 1000) begin tick1(); cnt++; end
    check("ws_left_slot", ws0, 0);

    // DECIM=1 pass-through, sign extension, tuser/tlast
    cnt = 0;
    while (q0.size() < 2 && cnt < 3000) begin tick1(); cnt++; end
    check("pass_beats", q0.size() >= 2, 1);
    check("pass_left", q0[0], mk(0, 3'd0, 32'h00123456));
    check("pass_right", q0[1], mk(1, 3'd1, 32'hFFFEDCBA));

    // DECIM=4 boxcar (one output by frame 6), DECIM=2 floor on negatives
    cnt = 0;
    while (tx_frm != 6 && cnt < 4000) begin tick1(); cnt++; end
    check("d4_count", q1.size(), 4);
    check("d4_ch0", q1[0], mk(0, 3'd0, 32'd10));
    check("d4_ch1", q1[1], mk(0, 3'd1, 32'hFFFFFFFE));
    check("d4_ch2", q1[2], mk(0, 3'd2, 32'd250));
    check("d4_ch3", q1[3], mk(1, 3'd3, 32'h007FFFFF));
    check("d2_ch0", q2[0], mk(0, 3'd0, 32'hFFFFFFFD));
    check("d2_ch1", q2[1], mk(1, 3'd1, 32'd5));
    check("d4_no_ovf", ovf1, 0);

    // Overflow: stall through two frames, then drain
    rst_n = 1'b0;
    rdy0  = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      w0l[k] = 24'(k + 1);
      w0r[k] = 24'(k + 'h100);
    end
    q0.delete();
    tick1();
    rst_n = 1'b1;
    cnt = 0;
    while (!ovf0 && cnt < 3000) begin tick1(); cnt++; end
    check("ovf_set", ovf0, 1);
    repeat (20) tick1();
    check("ovf_hold_valid", v0, 1);
    check("ovf_hold_data", d0, 32'd1);
    check("ovf_hold_user", u0u, 0);
    check("ovf_no_beats", q0.size(), 0);
    rdy0 = 1'b1;
    cnt = 0;
    while (q0.size() < 4 && cnt < 3000) begin tick1(); cnt++; end
    check("ovf_drain0", q0[0], mk(0, 3'd0, 32'd1));
    check("ovf_drain1", q0[1], mk(1, 3'd1, 32'h100));
    check("ovf_frame2_l", q0[2], mk(0, 3'd0, 32'd3));
    check("ovf_frame2_r", q0[3], mk(1, 3'd1, 32'h102));
    check("ovf_sticky", ovf0, 1);

    // Reset mid-frame (left-slot bit 10 of frame 1) with a word pending
    rst_n = 1'b0;
    rdy0  = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      w0l[k] = 24'h11;
      w0r[k] = 24'h22;
    end
    tick1();
    rst_n = 1'b1;
    cnt = 0;
    while (!(tx_frm == 1 && tx_pos == 11) && cnt < 3000) begin tick1(); cnt++; end
    check("mid_pending_valid", v0, 1);
    rst_n = 1'b0;
    #1;
    check("mid_clr_valid", v0, 0);
    check("mid_clr_data", d0, 0);
    check("mid_clr_last", l0, 0);
    check("mid_clr_sck", sck0, 0);
    for (int unsigned k = 0; k < 16; k++) begin
      w0l[k] = 24'h333;
      w0r[k] = 24'h444;
    end
    q0.delete();
    rdy0 = 1'b1;
    tick1();
    rst_n = 1'b1;
    cnt = 0;
    while (q0.size() < 2 && cnt < 3000) begin tick1(); cnt++; end
    check("mid_next_l", q0[0], mk(0, 3'd0, 32'h333));
    check("mid_next_r", q0[1], mk(1, 3'd1, 32'h444));
    check("mid_no_ovf", ovf0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
